instr_fetch_unit: RTL and testbench

//   Instruction fetch stage placed directly upstream of IDecoder. Holds the PC,

---
 rtl/instr_fetch_unit.sv | 147 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage feeding IDecoder.
// Holds the PC, issues one instruction-memory read per instruction, latches the
// returned word into the instruction register and computes the next PC.
// Only one instruction is in flight at a time, so an instruction takes at
// least three cycles: FETCH, WAIT (with rvalid) and EXEC.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | out of reset, nothing requested yet
// FETCH | imem_req pulses for this single cycle, address = pc
// WAIT  | request outstanding, waiting (unbounded) for imem_rvalid
// EXEC  | IR valid for IDecoder; stall holds here, otherwise pc advances
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_rvalid,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instruction,
    output logic             instr_valid,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    input  logic             stall,
    input  logic [1:0]       pc_mux_sel,
    input  logic             branch_cond,
    input  logic [31:0]      jr_addr,
    output logic [CNT_W-1:0] retired_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_EXEC  = 2'd3
    } state_t;

    localparam logic [1:0] SEL_SEQ    = 2'b00;
    localparam logic [1:0] SEL_BRANCH = 2'b01;
    localparam logic [1:0] SEL_JUMP   = 2'b10;
    localparam logic [1:0] SEL_JR     = 2'b11;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] ir_q;
    logic [31:0] p4;
    logic [31:0] branch_off;
    logic [31:0] next_pc;
    logic        ir_load;
    logic        pc_advance;

    // Sequential address and the sign-extended, word-scaled branch offset.
    assign p4         = pc_q + 32'd4;
    assign branch_off = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};

    // Next-PC selection; only consumed in the EXEC cycle that retires.
    always_comb begin
        next_pc = p4;
        case (pc_mux_sel)
            SEL_SEQ:    next_pc = p4;
            SEL_BRANCH: next_pc = branch_cond ? (p4 + branch_off) : p4;
            SEL_JUMP:   next_pc = {p4[31:28], ir_q[25:0], 2'b00};
            SEL_JR:     next_pc = jr_addr & 32'hFFFF_FFFC;
            default:    next_pc = p4;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic plus the load/advance strobes for the datapath.
    // rvalid is only honoured in WAIT so stale or late data never lands in IR.
    always_comb begin
        state_d    = state_q;
        ir_load    = 1'b0;
        pc_advance = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    ir_load = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!stall) begin
                    pc_advance = 1'b1;
                    state_d    = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // PC register: advances only when an instruction retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (pc_advance) begin
            pc_q <= next_pc;
        end
    end

    // Instruction register: resets to NOP, otherwise holds until the next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q <= 32'h0000_0000;
        end else if (ir_load) begin
            ir_q <= imem_rdata;
        end
    end

    // Retired-instruction counter, free to wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_cnt <= '0;
        end else if (pc_advance) begin
            retired_cnt <= retired_cnt + CNT_W'(1);
        end
    end

    // The request address is simply pc, so it stays put from FETCH through WAIT.
    assign imem_req    = (state_q == ST_FETCH);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == ST_EXEC);
    assign instruction = ir_q;
    assign pc          = pc_q;
    assign pc_plus4    = p4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit. Inputs change and outputs are sampled
// on the falling edge, half a cycle away from the active rising edge.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        stall;
    logic [1:0]  pc_mux_sel;
    logic        branch_cond;
    logic [31:0] jr_addr;
    logic [31:0] retired_cnt;

    int checks = 0;
    int errors = 0;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instruction(instruction), .instr_valid(instr_valid),
        .pc(pc), .pc_plus4(pc_plus4),
        .stall(stall), .pc_mux_sel(pc_mux_sel), .branch_cond(branch_cond),
        .jr_addr(jr_addr), .retired_cnt(retired_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Wait (bounded) until the DUT is in FETCH; called on a falling edge.
    task automatic wait_req(output bit to);
        to = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (imem_req === 1'b1) begin
                to = 1'b0;
                return;
            end
            @(negedge clk);
        end
    endtask

    // From FETCH: answer the request after d idle WAIT cycles; ends in EXEC.
    task automatic serve(input logic [31:0] rd, input int d);
        @(negedge clk);
        repeat (d) @(negedge clk);
        imem_rvalid = 1'b1;
        imem_rdata  = rd;
        @(negedge clk);
        imem_rvalid = 1'b0;
    endtask

    // From EXEC: retire with the given next-PC controls; ends in the next FETCH.
    task automatic retire(input logic [1:0] s, input logic c, input logic [31:0] j);
        pc_mux_sel  = s;
        branch_cond = c;
        jr_addr     = j;
        stall       = 1'b0;
        @(negedge clk);
    endtask

    task automatic one_instr(input logic [31:0] rd, input logic [1:0] s, input logic c,
                             input logic [31:0] j, output bit to);
        wait_req(to);
        if (to) return;
        serve(rd, 0);
        retire(s, c, j);
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
        checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL reset_ir: got %h expected %h", instruction, 32'h0); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        checks++; if (retired_cnt !== 32'h0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", retired_cnt); end
        rst_n = 1'b1;
    endtask

    task automatic test_sequential;
        bit to;
        for (int i = 0; i < 3; i++) begin
            wait_req(to);
            checks++; if (to) begin errors++; $display("FAIL seq_req_timeout: got none expected imem_req"); return; end
            checks++; if (imem_addr !== 32'(4 * i)) begin errors++; $display("FAIL seq_addr: got %h expected %h", imem_addr, 32'(4 * i)); end
            serve(32'h1000_0000 + 32'(i), 0);
            checks++; if (instruction !== 32'h1000_0000 + 32'(i)) begin errors++; $display("FAIL seq_ir: got %h expected %h", instruction, 32'h1000_0000 + 32'(i)); end
            checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL seq_valid: got %b expected 1", instr_valid); end
            retire(2'b00, 1'b0, 32'h0);
        end
        checks++; if (retired_cnt !== 32'd3) begin errors++; $display("FAIL seq_cnt: got %0d expected 3", retired_cnt); end
        checks++; if (pc !== 32'h0000_000C) begin errors++; $display("FAIL seq_pc: got %h expected %h", pc, 32'hC); end
    endtask

    task automatic test_slow_memory;
        bit to;
        wait_req(to);
        checks++; if (to) begin errors++; $display("FAIL slow_req_timeout: got none expected imem_req"); return; end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL slow_req_pulse: got %b expected 0", imem_req); end
            checks++; if (imem_addr !== 32'h0000_000C) begin errors++; $display("FAIL slow_addr_hold: got %h expected %h", imem_addr, 32'hC); end
            checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL slow_valid_early: got %b expected 0", instr_valid); end
        end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hCAFE_0003;
        @(negedge clk);
        imem_rvalid = 1'b0;
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL slow_valid: got %b expected 1", instr_valid); end
        checks++; if (instruction !== 32'hCAFE_0003) begin errors++; $display("FAIL slow_ir: got %h expected %h", instruction, 32'hCAFE_0003); end
        retire(2'b00, 1'b0, 32'h0);
        checks++; if (pc !== 32'h0000_0010) begin errors++; $display("FAIL slow_pc: got %h expected %h", pc, 32'h10); end
    endtask

    task automatic test_branch;
        bit to;
        one_instr(32'h1000_0001, 2'b01, 1'b1, 32'h0, to);
        checks++; if (pc !== 32'h0000_0018) begin errors++; $display("FAIL br_taken: got %h expected %h", pc, 32'h18); end
        one_instr(32'h0, 2'b11, 1'b0, 32'h0000_0010, to);
        one_instr(32'h1000_0001, 2'b01, 1'b0, 32'h0, to);
        checks++; if (pc !== 32'h0000_0014) begin errors++; $display("FAIL br_not_taken: got %h expected %h", pc, 32'h14); end
        one_instr(32'h0, 2'b11, 1'b0, 32'h0000_0010, to);
        one_instr(32'h1000_FFFF, 2'b01, 1'b1, 32'h0, to);
        checks++; if (pc !== 32'h0000_0010) begin errors++; $display("FAIL br_backward: got %h expected %h", pc, 32'h10); end
        checks++; if (to) begin errors++; $display("FAIL br_req_timeout: got none expected imem_req"); end
    endtask

    task automatic test_jump;
        bit to;
        one_instr(32'h0, 2'b11, 1'b0, 32'h4000_0000, to);
        checks++; if (pc !== 32'h4000_0000) begin errors++; $display("FAIL jr_setup: got %h expected %h", pc, 32'h4000_0000); end
        one_instr(32'h0800_0001, 2'b10, 1'b0, 32'h0, to);
        checks++; if (pc !== 32'h4000_0004) begin errors++; $display("FAIL j_target: got %h expected %h", pc, 32'h4000_0004); end
        one_instr(32'h0, 2'b11, 1'b0, 32'h0000_0103, to);
        checks++; if (pc !== 32'h0000_0100) begin errors++; $display("FAIL jr_align: got %h expected %h", pc, 32'h100); end
        checks++; if (retired_cnt !== 32'd12) begin errors++; $display("FAIL jump_cnt: got %0d expected 12", retired_cnt); end
    endtask

    task automatic test_stall;
        bit to;
        wait_req(to);
        checks++; if (to) begin errors++; $display("FAIL stall_req_timeout: got none expected imem_req"); return; end
        serve(32'hABCD_0000, 0);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            imem_rvalid = (i == 2);
            imem_rdata  = 32'hDEAD_BEEF;
            @(negedge clk);
            checks++; if (pc !== 32'h0000_0100) begin errors++; $display("FAIL stall_pc: got %h expected %h", pc, 32'h100); end
            checks++; if (instruction !== 32'hABCD_0000) begin errors++; $display("FAIL stall_ir: got %h expected %h", instruction, 32'hABCD_0000); end
            checks++; if (retired_cnt !== 32'd12) begin errors++; $display("FAIL stall_cnt: got %0d expected 12", retired_cnt); end
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req: got %b expected 0", imem_req); end
        end
        imem_rvalid = 1'b0;
        retire(2'b00, 1'b0, 32'h0);
        checks++; if (pc !== 32'h0000_0104) begin errors++; $display("FAIL stall_release_pc: got %h expected %h", pc, 32'h104); end
        checks++; if (retired_cnt !== 32'd13) begin errors++; $display("FAIL stall_release_cnt: got %0d expected 13", retired_cnt); end
    endtask

    task automatic test_wrap_and_reset;
        bit to;
        one_instr(32'h2222_2222, 2'b11, 1'b0, 32'hFFFF_FFFF, to);
        checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setup: got %h expected %h", pc, 32'hFFFF_FFFC); end
        checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_p4: got %h expected %h", pc_plus4, 32'h0); end
        one_instr(32'h3333_3333, 2'b00, 1'b0, 32'h0, to);
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h expected %h", pc, 32'h0); end
        one_instr(32'h4444_4444, 2'b00, 1'b0, 32'h0, to);
        wait_req(to);
        checks++; if (to) begin errors++; $display("FAIL rst_req_timeout: got none expected imem_req"); return; end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL midrst_pc: got %h expected %h", pc, 32'h0); end
        checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL midrst_ir: got %h expected %h", instruction, 32'h0); end
        checks++; if (retired_cnt !== 32'h0) begin errors++; $display("FAIL midrst_cnt: got %0d expected 0", retired_cnt); end
        @(negedge clk);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h5555_5555;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        imem_rvalid = 1'b0;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL post_rst_req: got %b expected 1", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL post_rst_addr: got %h expected %h", imem_addr, 32'h0); end
        checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL late_rvalid_ir: got %h expected %h", instruction, 32'h0); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL post_rst_valid: got %b expected 0", instr_valid); end
    endtask

    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        stall       = 1'b0;
        pc_mux_sel  = 2'b00;
        branch_cond = 1'b0;
        jr_addr     = 32'h0;
        test_reset();
        test_sequential();
        test_slow_memory();
        test_branch();
        test_jump();
        test_stall();
        test_wrap_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
